// File: rtl/montgomery_modexp.sv
// rtl/montgomery_modexp.sv - Montgomery modular exponentiation, one REDC per clock
//
// Purpose: computes result = base^exponent mod modulant with left-to-right
// square-and-multiply in the Montgomery domain. A single combinational REDC
// is shared by every step, so each FSM state consumes exactly one cycle.
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   reset        - synchronous active-high reset, overrides start
//   start        - request, sampled only in IDLE
//   base         - base, expected < modulant
//   exponent     - exponent, all DATA_WIDTH bits scanned MSB first
//   modulant     - odd modulus n, expected < R
//   modulant_inv - -n^-1 mod R
//   R_minus_one  - R-1 mask
//   bit_length   - log2(R), at most DATA_WIDTH
//   r2_mod       - R^2 mod n
//   busy         - high while an operation is in flight
//   done         - one-cycle pulse, result valid
//   result       - final value, held until the next done
module montgomery_modexp #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [DATA_WIDTH-1:0] exponent,
  input  logic [DATA_WIDTH-1:0] modulant,
  input  logic [DATA_WIDTH-1:0] modulant_inv,
  input  logic [DATA_WIDTH-1:0] R_minus_one,
  input  logic [DATA_WIDTH-1:0] bit_length,
  input  logic [DATA_WIDTH-1:0] r2_mod,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W2 = 2 * DATA_WIDTH;
  localparam int W1 = DATA_WIDTH + 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CONV_B    = 3'd1,
    S_CONV_ONE  = 3'd2,
    S_SQUARE    = 3'd3,
    S_MULT      = 3'd4,
    S_FROM_MONT = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Operands captured at start; the live inputs are ignored afterwards.
  logic [DATA_WIDTH-1:0] r_base;
  logic [DATA_WIDTH-1:0] r_exp;
  logic [DATA_WIDTH-1:0] r_n;
  logic [DATA_WIDTH-1:0] r_ninv;
  logic [DATA_WIDTH-1:0] r_rmask;
  logic [DATA_WIDTH-1:0] r_bit_length;
  logic [DATA_WIDTH-1:0] r_r2;

  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_bm;
  logic [IW-1:0]         r_i;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_done;

  logic [DATA_WIDTH-1:0] w_op_a;
  logic [DATA_WIDTH-1:0] w_op_b;
  logic [W2-1:0]         w_t;
  logic [DATA_WIDTH-1:0] w_m;
  logic [W2-1:0]         w_mn;
  logic [W2:0]           w_sum;
  logic [W1-1:0]         w_u;
  logic [DATA_WIDTH-1:0] w_redc;

  // Multiplier operand selection for the shared REDC.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    case (r_state)
      S_CONV_B: begin
        w_op_a = r_base;
        w_op_b = r_r2;
      end
      S_CONV_ONE: begin
        w_op_a = DATA_WIDTH'(1);
        w_op_b = r_r2;
      end
      S_SQUARE: begin
        w_op_a = r_acc;
        w_op_b = r_acc;
      end
      S_MULT: begin
        w_op_a = r_acc;
        w_op_b = r_bm;
      end
      S_FROM_MONT: begin
        w_op_a = r_acc;
        w_op_b = DATA_WIDTH'(1);
      end
      default: begin
        w_op_a = '0;
        w_op_b = '0;
      end
    endcase
  end

  // REDC(t) = (t + m*n) / R, m = (t mod R) * n' mod R. The sum needs one
  // bit beyond 2W; after the shift the value is below 2n, so W+1 bits hold it
  // and a single conditional subtraction finishes the reduction.
  assign w_t    = W2'(w_op_a) * W2'(w_op_b);
  assign w_m    = ((w_t[DATA_WIDTH-1:0] & r_rmask) * r_ninv) & r_rmask;
  assign w_mn   = W2'(w_m) * W2'(r_n);
  assign w_sum  = {1'b0, w_t} + {1'b0, w_mn};
  assign w_u    = W1'(w_sum >> r_bit_length);
  assign w_redc = (w_u >= {1'b0, r_n}) ? DATA_WIDTH'(w_u - {1'b0, r_n})
                                       : w_u[DATA_WIDTH-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      w_next_state = start ? S_CONV_B : S_IDLE;
      S_CONV_B:    w_next_state = S_CONV_ONE;
      S_CONV_ONE:  w_next_state = S_SQUARE;
      S_SQUARE: begin
        if (r_exp[r_i]) begin
          w_next_state = S_MULT;
        end else if (r_i == '0) begin
          w_next_state = S_FROM_MONT;
        end else begin
          w_next_state = S_SQUARE;
        end
      end
      S_MULT:      w_next_state = (r_i == '0) ? S_FROM_MONT : S_SQUARE;
      S_FROM_MONT: w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    busy   = (r_state != S_IDLE);
    done   = r_done;
    result = r_result;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base       <= '0;
      r_exp        <= '0;
      r_n          <= '0;
      r_ninv       <= '0;
      r_rmask      <= '0;
      r_bit_length <= '0;
      r_r2         <= '0;
      r_acc        <= '0;
      r_bm         <= '0;
      r_i          <= '0;
      r_result     <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (r_state == S_FROM_MONT);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base       <= base;
            r_exp        <= exponent;
            r_n          <= modulant;
            r_ninv       <= modulant_inv;
            r_rmask      <= R_minus_one;
            r_bit_length <= bit_length;
            r_r2         <= r2_mod;
          end
        end
        S_CONV_B: begin
          r_bm <= w_redc;
        end
        S_CONV_ONE: begin
          r_acc <= w_redc;
          r_i   <= IW'(DATA_WIDTH - 1);
        end
        S_SQUARE: begin
          r_acc <= w_redc;
          // A set bit keeps i for the following MULT, which decrements it.
          if (!r_exp[r_i] && (r_i != '0)) begin
            r_i <= r_i - IW'(1);
          end
        end
        S_MULT: begin
          r_acc <= w_redc;
          if (r_i != '0) begin
            r_i <= r_i - IW'(1);
          end
        end
        S_FROM_MONT: begin
          r_result <= w_redc;
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_modexp.sv
// tb/tb_montgomery_modexp.sv - self-checking bench for montgomery_modexp
module tb_montgomery_modexp;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] base;
  logic [7:0] exponent;
  logic [7:0] modulant;
  logic [7:0] modulant_inv;
  logic [7:0] R_minus_one;
  logic [7:0] bit_length;
  logic [7:0] r2_mod;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] n;
    logic [7:0] ninv;
    logic [7:0] rmask;
    logic [7:0] blen;
    logic [7:0] r2;
    logic [7:0] b;
    logic [7:0] e;
    logic [7:0] res;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  montgomery_modexp #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base         (base),
    .exponent     (exponent),
    .modulant     (modulant),
    .modulant_inv (modulant_inv),
    .R_minus_one  (R_minus_one),
    .bit_length   (bit_length),
    .r2_mod       (r2_mod),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_cfg(input vec_t v);
    modulant     = v.n;
    modulant_inv = v.ninv;
    R_minus_one  = v.rmask;
    bit_length   = v.blen;
    r2_mod       = v.r2;
    base         = v.b;
    exponent     = v.e;
  endtask

  task automatic scramble();
    base         = 8'($urandom);
    exponent     = 8'($urandom);
    modulant     = 8'($urandom);
    modulant_inv = 8'($urandom);
    R_minus_one  = 8'($urandom);
    bit_length   = 8'($urandom);
    r2_mod       = 8'($urandom);
  endtask

  // Start one operation, scramble the inputs while busy, and check
  // latency (edges after the accepting edge), result and done width.
  task automatic run_op(input vec_t v, input string tag);
    int k;
    @(negedge clk);
    drive_cfg(v);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, " busy_after_start"}, int'(busy), 1);
    scramble();
    k = 0;
    while (!done && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, " latency"}, k, v.lat);
    chk({tag, " result"}, int'(result), int'(v.res));
    chk({tag, " busy_at_done"}, int'(busy), 0);
    @(posedge clk);
    #1;
    chk({tag, " done_width"}, int'(done), 0);
  endtask

  initial begin
    int         first_done;
    int         second_done;
    int         ndone;
    int         k;
    vec_t       va;

    // n=13, R=16
    vecs[0] = '{8'd13, 8'd11, 8'd15, 8'd4, 8'd9, 8'd3,   8'd5,   8'd9,   13};
    vecs[1] = '{8'd13, 8'd11, 8'd15, 8'd4, 8'd9, 8'd7,   8'd12,  8'd1,   13};
    vecs[2] = '{8'd13, 8'd11, 8'd15, 8'd4, 8'd9, 8'd12,  8'd255, 8'd12,  19};
    vecs[3] = '{8'd13, 8'd11, 8'd15, 8'd4, 8'd9, 8'd2,   8'd0,   8'd1,   11};
    vecs[4] = '{8'd13, 8'd11, 8'd15, 8'd4, 8'd9, 8'd5,   8'd2,   8'd12,  12};
    vecs[5] = '{8'd13, 8'd11, 8'd15, 8'd4, 8'd9, 8'd4,   8'd128, 8'd3,   12};
    vecs[6] = '{8'd13, 8'd11, 8'd15, 8'd4, 8'd9, 8'd0,   8'd3,   8'd0,   13};
    // n=11, R=16
    vecs[7] = '{8'd11, 8'd13, 8'd15, 8'd4, 8'd3, 8'd2,   8'd10,  8'd1,   13};
    // n=251, R=256 (full-width products)
    vecs[8] = '{8'd251, 8'd205, 8'd255, 8'd8, 8'd25, 8'd2,   8'd8, 8'd5,   12};
    vecs[9] = '{8'd251, 8'd205, 8'd255, 8'd8, 8'd25, 8'd250, 8'd3, 8'd250, 13};
    va = vecs[0];

    reset = 1'b1;
    start = 1'b0;
    drive_cfg(va);
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset result", int'(result), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v], $sformatf("vec%0d", v));
    end

    // Reset in the middle of an operation, with start held high.
    @(negedge clk);
    drive_cfg(va);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midop busy", int'(busy), 1);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("midop reset busy", int'(busy), 0);
    chk("midop reset done", int'(done), 0);
    chk("midop reset result", int'(result), 0);
    @(posedge clk);
    #1;
    chk("reset over start busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("idle after reset busy", int'(busy), 0);
    chk("idle after reset result", int'(result), 0);
    run_op(va, "post_reset");

    // start held high from acceptance through two completions.
    @(negedge clk);
    drive_cfg(va);
    start = 1'b1;
    @(posedge clk);
    #1;
    first_done  = -1;
    second_done = -1;
    ndone       = 0;
    k           = 0;
    while (ndone < 2 && k < 60) begin
      @(posedge clk);
      #1;
      k++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first_done = k;
          chk("held first result", int'(result), 9);
        end else begin
          second_done = k;
          chk("held second result", int'(result), 9);
          start = 1'b0;
        end
      end
      if (first_done > 0 && k == first_done + 1) begin
        chk("held done width", int'(done), 0);
        chk("held restart busy", int'(busy), 1);
      end
    end
    start = 1'b0;
    chk("held done count", ndone, 2);
    chk("held first latency", first_done, 13);
    chk("held second latency", second_done - first_done, 14);
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("no extra done", ndone, 0);
    chk("final busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/montgomery_modexp.md
MONTGOMERY_MODEXP -- requirements
Module: montgomery_modexp

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, operand/modulus width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: base  input  DATA_WIDTH  base, required < modulant.
REQ-006 SHALL have port: exponent  input  DATA_WIDTH  exponent, all DATA_WIDTH bits scanned.
REQ-007 SHALL have port: modulant  input  DATA_WIDTH  odd modulus n, required < R.
REQ-008 SHALL have port: modulant_inv  input  DATA_WIDTH  -n^-1 mod R.
REQ-009 SHALL have port: R_minus_one  input  DATA_WIDTH  R-1 mask, R = 2^bit_length.
REQ-010 SHALL have port: bit_length  input  DATA_WIDTH  log2(R), at most DATA_WIDTH.
REQ-011 SHALL have port: r2_mod  input  DATA_WIDTH  R^2 mod n.
REQ-012 SHALL have port: busy  output  1  high while an operation is in flight.
REQ-013 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-014 SHALL have port: result  output  DATA_WIDTH  base^exponent mod n; held until next done.

Function
REQ-015 SHALL compute with one shared combinational Montgomery reduction, REDC(t) = (t + ((t mod R)*modulant_inv mod R)*n)/R, conditionally minus n, performing exactly one REDC per clock cycle.
REQ-016 SHALL, on a rising edge in IDLE with start=1, latch base, exponent, modulant, modulant_inv, R_minus_one, bit_length and r2_mod, and set busy=1; the latched copies SHALL be used for the whole operation.
REQ-017 SHALL implement the states IDLE, CONV_B, CONV_ONE, SQUARE, MULT and FROM_MONT.
REQ-018 CONV_B SHALL register bm = REDC(base*r2_mod), then go to CONV_ONE.
REQ-019 CONV_ONE SHALL register acc = REDC(1*r2_mod), set bit index i = DATA_WIDTH-1, then go to SQUARE.
REQ-020 SQUARE SHALL register acc = REDC(acc*acc); if exponent[i]=1, go to MULT; else, if i=0, go to FROM_MONT, otherwise decrement i and stay in SQUARE.
REQ-021 MULT SHALL register acc = REDC(acc*bm); if i=0, go to FROM_MONT, otherwise decrement i and go to SQUARE.
REQ-022 FROM_MONT SHALL register result = REDC(acc*1), assert done=1 for the next cycle only, clear busy on the same edge, and return to IDLE.
REQ-023 Products SHALL be formed at 2*DATA_WIDTH width with no truncation before reduction.
REQ-024 Latency: with start sampled at edge E0 and p = popcount(exponent), done SHALL be high in the cycle following edge E0+DATA_WIDTH+p+3.
REQ-025 start SHALL be ignored while busy=1; input changes during busy SHALL not affect result.
REQ-026 start=1 on the edge at which done is asserted SHALL NOT be accepted; start SHALL be accepted on the following edge, when the block is in IDLE.
REQ-027 exponent=0 SHALL yield result = 1 mod n, with latency DATA_WIDTH+3.
REQ-028 Behaviour for even modulant, modulant >= R, or base >= modulant is unspecified; the block SHALL NOT flag these cases.

Reset
REQ-029 reset=1 at any edge, including mid-operation, SHALL force IDLE and busy=0, done=0, result=0, and clear acc, bm, i and all latched operands.
REQ-030 reset SHALL take priority over start on the same edge.

Verification
REQ-031 DATA_WIDTH=8, n=13, R=16 (bit_length=4, R_minus_one=15), modulant_inv=11, r2_mod=9, base=3, exponent=5 -> result=9, done after 13 edges.
REQ-032 Same config, base=7, exponent=12 -> result=1, done after 13 edges.
REQ-033 Same config, base=12, exponent=255 -> result=12, done after 19 edges.
REQ-034 Same config, base=2, exponent=0 -> result=1, done after 11 edges.
REQ-035 Assert reset at the 5th edge of an operation, then start base=3, exponent=5 -> outputs 0 during reset, then result=9 with nominal latency.
REQ-036 Pulse start while busy, then hold start high through done -> only one result is produced per accepted start, done is exactly one cycle wide, and the next operation starts one edge after done.
